sipo_framed: RTL and testbench

Parametrised successor to the single-bit serial-in/parallel-out register. It accepts LANES bits per load strobe, shifts either MSB-first or LSB-first, and counts beats toward a WIDTH-bit word. On each completed word it raises a one-cycle word_valid strobe and presents the assembled word. It sits between a slow serial or narrow link and word-oriented logic, and replaces any external bit counting around the plain shift register.

---
 rtl/sipo_framed_pkg.sv | 18 +
 rtl/sipo_framed_beat_counter.sv | 30 +++
 rtl/sipo_framed.sv | 88 ++++++++
 tb/tb_sipo_framed.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_framed_pkg.sv
// Shared types and elaboration helpers for the framed serial-in/parallel-out register.
package sipo_pkg;

  typedef enum logic {
    SHIFT_LSB_FIRST = 1'b0,
    SHIFT_MSB_FIRST = 1'b1
  } shift_dir_e;

  function automatic int unsigned beats(input int unsigned width, input int unsigned lanes);
    return width / lanes;
  endfunction

  // Counter width, never narrower than one bit even for a single-beat word.
  function automatic int unsigned cnt_bits(input int unsigned n_beats);
    return (n_beats <= 2) ? 1 : $clog2(n_beats);
  endfunction

endpackage

// File: rtl/sipo_framed_beat_counter.sv
// Beat counter that wraps at a terminal count; wrap flags the beat that completes a word.
module sipo_beat_counter
  import sipo_pkg::*;
#(
  parameter int unsigned TERMINAL = 0,
  parameter int unsigned BW       = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [BW-1:0] cnt,
  output logic          wrap
);

  localparam logic [BW-1:0] TERM = BW'(TERMINAL);

  assign wrap = inc && (cnt == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_framed.sv
// Multi-lane SIPO with beat counting and a one-cycle word_valid strobe per completed word.
// Define SIPO_FRAMED_HOLD_EN to present completed words from a holding register.
module sipo_framed
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 42,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        load,
  input  logic [LANES-1:0]                            data_in,
  input  logic                                        clear,
  output logic [WIDTH-1:0]                            data_out,
  output logic                                        word_valid,
  output logic [cnt_bits(beats(WIDTH, LANES))-1:0]    beat_count
);

  localparam int unsigned BEATS = beats(WIDTH, LANES);
  localparam int unsigned BW    = cnt_bits(BEATS);
  localparam shift_dir_e  DIR   = shift_dir_e'(MSB_FIRST);

  if ((LANES == 0) || (LANES > WIDTH) || (WIDTH % LANES != 0)) begin : g_bad_cfg
    $fatal(1, "sipo_framed: WIDTH (%0d) must be a non-zero multiple of LANES (%0d)", WIDTH, LANES);
  end

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic             accept;
  logic             wrap;

  assign accept = load && !clear;

  // Single-beat words replace sr outright; the generic slices would be empty ranges.
  if (LANES == WIDTH) begin : g_full
    always_comb sr_shift = data_in;
  end else if (DIR == SHIFT_MSB_FIRST) begin : g_msb
    always_comb sr_shift = {sr[WIDTH-LANES-1:0], data_in};
  end else begin : g_lsb
    always_comb sr_shift = {data_in, sr[WIDTH-1:LANES]};
  end

  sipo_beat_counter #(
    .TERMINAL (BEATS - 1),
    .BW       (BW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (accept),
    .cnt   (beat_count),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr         <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= wrap;
      if (clear) begin
        sr <= '0;
      end else if (load) begin
        sr <= sr_shift;
      end
    end
  end

`ifdef SIPO_FRAMED_HOLD_EN
  logic [WIDTH-1:0] hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (clear) begin
      hold <= '0;
    end else if (wrap) begin
      hold <= sr_shift;
    end
  end

  assign data_out = hold;
`else
  assign data_out = sr;
`endif

endmodule

// File: tb/tb_sipo_framed.sv
// Directed + random bench for sipo_framed across four configurations, checked against a bit-history model.
module tb_sipo_framed;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ld  [4];
  logic        clr [4];
  logic [63:0] din [4];

  logic [7:0]  do0;
  logic [7:0]  do1;
  logic [41:0] do2;
  logic [3:0]  do3;
  logic [3:0]  wvo;
  logic [2:0]  bc0;
  logic [1:0]  bc1;
  logic [5:0]  bc2;
  logic [0:0]  bc3;

  sipo_framed #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) u_d0 (
    .clk(clk), .rst(rst), .load(ld[0]), .data_in(din[0][0:0]), .clear(clr[0]),
    .data_out(do0), .word_valid(wvo[0]), .beat_count(bc0));
  sipo_framed #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .load(ld[1]), .data_in(din[1][1:0]), .clear(clr[1]),
    .data_out(do1), .word_valid(wvo[1]), .beat_count(bc1));
  sipo_framed #(.WIDTH(42), .LANES(1), .MSB_FIRST(1'b1)) u_d2 (
    .clk(clk), .rst(rst), .load(ld[2]), .data_in(din[2][0:0]), .clear(clr[2]),
    .data_out(do2), .word_valid(wvo[2]), .beat_count(bc2));
  sipo_framed #(.WIDTH(4), .LANES(4), .MSB_FIRST(1'b1)) u_d3 (
    .clk(clk), .rst(rst), .load(ld[3]), .data_in(din[3][3:0]), .clear(clr[3]),
    .data_out(do3), .word_valid(wvo[3]), .beat_count(bc3));

  logic [63:0] dout [4];
  logic [7:0]  bcnt [4];
  always_comb begin
    dout[0] = 64'(do0); dout[1] = 64'(do1); dout[2] = 64'(do2); dout[3] = 64'(do3);
    bcnt[0] = 8'(bc0);  bcnt[1] = 8'(bc1);  bcnt[2] = 8'(bc2);  bcnt[3] = 8'(bc3);
  end

  // Reference model: arrival-ordered bit history per instance.
  int unsigned W  [4] = '{8, 8, 42, 4};
  int unsigned L  [4] = '{1, 2, 1, 4};
  bit          MF [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit          hist [4][0:4095];
  int          nbit  [4];
  int          nbeat [4];
  logic [63:0] hold  [4];
  logic        wv_exp [4];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Most recent bit lands at bit 0 (MSB-first) or bit W-1 (LSB-first); older bits fan out from there.
  function automatic logic [63:0] exp_sr(input int d);
    logic [63:0] r = '0;
    for (int i = 0; i < int'(W[d]); i++) begin
      int idx = nbit[d] - 1 - i;
      if (idx >= 0 && hist[d][idx]) begin
        if (MF[d]) r[i] = 1'b1;
        else       r[int'(W[d]) - 1 - i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_out(input int d);
`ifdef SIPO_FRAMED_HOLD_EN
    return hold[d];
`else
    return exp_sr(d);
`endif
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      nbit[d] = 0; nbeat[d] = 0; hold[d] = '0; wv_exp[d] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_d%0d_data", tag, d), dout[d], exp_out(d));
      chk($sformatf("%s_d%0d_valid", tag, d), 64'(wvo[d]), 64'(wv_exp[d]));
      chk($sformatf("%s_d%0d_count", tag, d), 64'(bcnt[d]),
          64'(nbeat[d] % (W[d] / L[d])));
    end
  endtask

  task automatic set_idle();
    for (int d = 0; d < 4; d++) begin
      ld[d] = 1'b0; clr[d] = 1'b0; din[d] = 'x;
    end
  endtask

  // One clock: apply model to the inputs sampled at this edge, check, then idle the inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      wv_exp[d] = 1'b0;
      if (clr[d]) begin
        nbit[d] = 0; nbeat[d] = 0; hold[d] = '0;
      end else if (ld[d]) begin
        for (int j = 0; j < int'(L[d]); j++) begin
          int lane = MF[d] ? int'(L[d]) - 1 - j : j;
          hist[d][nbit[d]] = din[d][lane];
          nbit[d]++;
        end
        nbeat[d]++;
        if (nbeat[d] % (W[d] / L[d]) == 0) begin
          wv_exp[d] = 1'b1;
          hold[d]   = exp_sr(d);
        end
      end
    end
    check_all("cyc");
    set_idle();
  endtask

  task automatic beat(input int d, input logic [63:0] v);
    ld[d] = 1'b1; din[d] = v;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  a5;
    logic [41:0] w1;
    logic [41:0] w2;
    logic [1:0]  l2 [4];
    logic [7:0]  bcs [4];

    set_idle();
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 8-bit MSB-first, sparse beats -> A5
    a5 = 8'hA5;
    for (int k = 7; k >= 0; k--) begin
      beat(0, 64'(a5[k]));
      if (k == 0) begin
        chk("a5_word", dout[0], 64'hA5);
        chk("a5_valid", 64'(wvo[0]), 64'd1);
      end else begin
        idle($urandom_range(5, 21));
      end
    end
    idle(2);

    // 8-bit, 2 lanes, LSB-first, continuous -> 39
    l2  = '{2'b01, 2'b10, 2'b11, 2'b00};
    bcs = '{8'd1, 8'd2, 8'd3, 8'd0};
    for (int k = 0; k < 4; k++) begin
      beat(1, 64'(l2[k]));
      chk($sformatf("lsb_count%0d", k), 64'(bcnt[1]), 64'(bcs[k]));
    end
    chk("lsb_word", dout[1], 64'h39);
    chk("lsb_valid", 64'(wvo[1]), 64'd1);
    idle(1);

    // 42-bit back-to-back words
    w1 = 42'h2AA_AAAA_AAAA;
    w2 = 42'h155_5555_5555;
    for (int k = 41; k >= 0; k--) beat(2, 64'(w1[k]));
    chk("w42_first", dout[2], 64'(w1));
    for (int k = 41; k >= 22; k--) beat(2, 64'(w2[k]));
`ifdef SIPO_FRAMED_HOLD_EN
    chk("w42_held", dout[2], 64'(w1));
`endif
    for (int k = 21; k >= 0; k--) beat(2, 64'(w2[k]));
    chk("w42_second", dout[2], 64'(w2));
    chk("w42_valid", 64'(wvo[2]), 64'd1);
    idle(1);

    // partial word, then clear with load, then C3
    for (int k = 0; k < 5; k++) beat(0, 64'($urandom_range(0, 1)));
    clr[0] = 1'b1; ld[0] = 1'b1; din[0] = 64'd1;
    tick();
    chk("clr_count", 64'(bcnt[0]), 64'd0);
    chk("clr_data", dout[0], 64'd0);
    a5 = 8'hC3;
    for (int k = 7; k >= 0; k--) beat(0, 64'(a5[k]));
    chk("clr_word", dout[0], 64'hC3);
    chk("clr_valid", 64'(wvo[0]), 64'd1);
    idle(1);

    // async reset between edges after 3 beats
    for (int k = 0; k < 3; k++) beat(0, 64'd1);
    rst = 1'b1;
    #2;
    model_reset();
    check_all("arst");
    #1;
    rst = 1'b0;
    a5 = 8'h5A;
    for (int k = 7; k >= 0; k--) beat(0, 64'(a5[k]));
    chk("arst_word", dout[0], 64'h5A);
    idle(1);

    // single-beat words: consecutive strobes
    for (int k = 1; k <= 3; k++) begin
      beat(3, 64'(k));
      chk($sformatf("full_valid%0d", k), 64'(wvo[3]), 64'd1);
      chk($sformatf("full_data%0d", k), dout[3], 64'(k));
    end
    idle(1);

    // random traffic on all instances
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 4; d++) begin
        ld[d]  = ($urandom_range(0, 9) < 6);
        clr[d] = ($urandom_range(0, 39) == 0);
        din[d] = ld[d] ? {$urandom, $urandom} : 'x;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
